// File: rtl/img_crop_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : img_crop_streamer
//  Description : Reads a rectangular crop window out of an image memory in
//                raster order and streams the pixels on an AXI-Stream master
//                through a 2-entry skid FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module img_crop_streamer #(
   parameter  int FP_TOTAL = 16,
   parameter  int IN_ROWS  = 100,
   parameter  int IN_COLS  = 160,
   parameter  int OUT_ROWS = 48,
   parameter  int OUT_COLS = 48,
   parameter  int Y_1      = 10,
   parameter  int X_1      = 10,
   localparam int AW       = $clog2(IN_ROWS * IN_COLS)
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   input  logic                ap_start,
   output logic                ap_done,
   output logic                ap_idle,
   output logic                ap_ready,
   output logic [AW-1:0]       img_addr,
   output logic                img_rd_en,
   input  logic [FP_TOTAL-1:0] img_rdata,
   output logic [FP_TOTAL-1:0] conv2d_1_input_V_data_0_V_TDATA,
   output logic                conv2d_1_input_V_data_0_V_TVALID,
   input  logic                conv2d_1_input_V_data_0_V_TREADY
);

   localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
   localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

   localparam logic [RW-1:0] c_last_row  = RW'(OUT_ROWS - 1);
   localparam logic [CW-1:0] c_last_col  = CW'(OUT_COLS - 1);
   localparam logic [AW-1:0] c_base_init = AW'(Y_1 * IN_COLS + X_1);
   localparam logic [AW-1:0] c_in_cols   = AW'(IN_COLS);

   // A crop window that overhangs the source image is rejected at elaboration.
   generate
      if ((Y_1 + OUT_ROWS > IN_ROWS) || (X_1 + OUT_COLS > IN_COLS)) begin : g_cfg_bad
         $error("img_crop_streamer: crop window exceeds source image");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_next;

   logic [RW-1:0]         r_row;
   logic [CW-1:0]         r_col;
   logic [AW-1:0]         r_row_base;

   logic [FP_TOTAL-1:0]   r_mem [0:1];
   logic                  r_wr_ptr;
   logic                  r_rd_ptr;
   logic [1:0]            r_count;
   logic                  r_inflight;
   logic                  r_tvalid;

   logic                  w_pop;
   logic                  w_push;
   logic [1:0]            w_occ_after;
   logic [1:0]            w_count_next;
   logic                  w_rd_en;
   logic                  w_last_read;

   // Read throttling and FIFO occupancy bookkeeping. A pop in the same cycle
   // frees a slot, which is what lets the stream sustain one beat per cycle.
   always_comb begin
      w_pop        = r_tvalid & conv2d_1_input_V_data_0_V_TREADY;
      w_push       = r_inflight;
      w_occ_after  = r_count - {1'b0, w_pop};
      w_rd_en      = (r_state == S_STREAM) &&
                     (({1'b0, w_occ_after} + {2'b00, r_inflight}) < 3'd2);
      w_last_read  = w_rd_en && (r_row == c_last_row) && (r_col == c_last_col);
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 2'd1;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - 2'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      ap_idle      = 1'b0;
      ap_done      = 1'b0;
      ap_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               w_state_next = S_STREAM;
            end
         end
         S_STREAM: begin
            if (w_last_read) begin
               w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Nothing outstanding and the last buffered beat leaves this cycle.
            if (!r_inflight && (w_count_next == 2'd0)) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            ap_done      = 1'b1;
            ap_ready     = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Raster counters; the row base steps by IN_COLS so no multiplier is needed.
   // They rewind on the final read so the next frame starts at the corner.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_row      <= '0;
         r_col      <= '0;
         r_row_base <= c_base_init;
      end else if (w_rd_en) begin
         if (r_col == c_last_col) begin
            r_col <= '0;
            if (r_row == c_last_row) begin
               r_row      <= '0;
               r_row_base <= c_base_init;
            end else begin
               r_row      <= r_row + RW'(1);
               r_row_base <= r_row_base + c_in_cols;
            end
         end else begin
            r_col <= r_col + CW'(1);
         end
      end
   end

   // Output FIFO: read data lands one cycle after the strobe; TVALID is a
   // registered copy of "FIFO will be non-empty".
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < 2; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
         r_tvalid   <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         r_count    <= w_count_next;
         r_tvalid   <= (w_count_next != 2'd0);
         if (w_push) begin
            r_mem[r_wr_ptr] <= img_rdata;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
      end
   end

   assign img_rd_en = w_rd_en;
   assign img_addr  = (r_state == S_STREAM) ? (r_row_base + AW'(r_col)) : '0;

   assign conv2d_1_input_V_data_0_V_TDATA  = r_mem[r_rd_ptr];
   assign conv2d_1_input_V_data_0_V_TVALID = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_img_crop_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_crop_streamer
//  Description : Scoreboard bench for img_crop_streamer with a mem[a]=a
//                image memory and default parameters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_img_crop_streamer;

   localparam int NBEATS = 48 * 48;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic [13:0] img_addr;
   logic        img_rd_en;
   logic [15:0] img_rdata = 16'h0;
   logic [15:0] tdata;
   logic        tvalid;
   logic        tready;

   img_crop_streamer dut (
      .ap_clk                           (ap_clk),
      .ap_rst_n                         (ap_rst_n),
      .ap_start                         (ap_start),
      .ap_done                          (ap_done),
      .ap_idle                          (ap_idle),
      .ap_ready                         (ap_ready),
      .img_addr                         (img_addr),
      .img_rd_en                        (img_rd_en),
      .img_rdata                        (img_rdata),
      .conv2d_1_input_V_data_0_V_TDATA  (tdata),
      .conv2d_1_input_V_data_0_V_TVALID (tvalid),
      .conv2d_1_input_V_data_0_V_TREADY (tready)
   );

   always #5 ap_clk = ~ap_clk;

   // Image memory: mem[a] = a, data one cycle after the strobe, junk otherwise.
   always @(posedge ap_clk) img_rdata <= img_rd_en ? 16'(img_addr) : 16'hDEAD;

   int cyc = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] sb_q[$];
   logic [15:0] frame_log [0:NBEATS-1];
   int          frame_beats = 0;
   int          beats_total = 0;
   int          done_total  = 0;
   int          reads_total = 0;
   int          first_cyc = 0, last_cyc = 0, done_cyc = 0;
   bit          rand_rdy = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_max(input string name, input int act, input int lim);
      n_cmp++;
      if (act > lim) begin
         n_err++;
         $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic pulse_start();
      ap_start = 1'b1;
      step();
      ap_start = 1'b0;
   endtask

   task automatic push_frame();
      for (int r = 0; r < 48; r++)
         for (int c = 0; c < 48; c++)
            sb_q.push_back(16'((10 + r) * 160 + 10 + c));
   endtask

   task automatic wait_done(input string name, input int bound);
      int d0 = done_total;
      for (int i = 0; i < bound; i++) begin
         step();
         if (done_total > d0) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s: no ap_done within %0d cycles", name, bound);
   endtask

   task automatic wait_beats(input string name, input int target, input int bound);
      for (int i = 0; i < bound; i++) begin
         if (frame_beats >= target) return;
         step();
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s: beat count %0d never reached %0d", name, frame_beats, target);
   endtask

   // Monitor: pops the scoreboard on every transferred beat and checks the
   // handshake rules, sampling on the falling edge.
   initial begin
      logic [15:0] exp_v;
      logic        p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b0;
      logic [15:0] p_data = '0;
      forever begin
         @(negedge ap_clk);
         if (ap_rst_n && p_rst && p_valid && !p_ready) begin
            n_cmp++;
            if (!tvalid || tdata !== p_data) begin
               n_err++;
               $display("FAIL hold: valid %0b data %0d expected valid 1 data %0d", tvalid, tdata, p_data);
            end
         end
         if (tvalid && tready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL beat: got unexpected beat %0d expected none", tdata);
            end else begin
               exp_v = sb_q.pop_front();
               if (tdata !== exp_v) begin
                  n_err++;
                  $display("FAIL beat: got %0d expected %0d", tdata, exp_v);
               end
            end
            if (frame_beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            if (frame_beats < NBEATS) frame_log[frame_beats] = tdata;
            frame_beats++;
            beats_total++;
         end
         if (ap_done || ap_ready) begin
            check("ready_eq_done", int'(ap_ready), int'(ap_done));
         end
         if (ap_done) begin
            done_total++;
            done_cyc = cyc;
         end
         if (img_rd_en) reads_total++;
         p_valid = tvalid;
         p_ready = tready;
         p_data  = tdata;
         p_rst   = ap_rst_n;
      end
   end

   // Random downstream readiness (about 3/4 high) when enabled.
   initial begin
      forever begin
         @(posedge ap_clk);
         #1;
         if (rand_rdy) tready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, b0, start_cyc;
      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      tready   = 1'b0;

      // Reset values
      repeat (3) step();
      check("rst_tvalid", int'(tvalid), 0);
      check("rst_tdata", int'(tdata), 0);
      check("rst_rd_en", int'(img_rd_en), 0);
      check("rst_addr", int'(img_addr), 0);
      check("rst_idle", int'(ap_idle), 1);
      check("rst_done", int'(ap_done), 0);
      check("rst_ready", int'(ap_ready), 0);
      ap_rst_n = 1'b1;
      repeat (2) step();

      // Full throughput
      tready = 1'b1;
      frame_beats = 0;
      d0 = done_total;
      push_frame();
      start_cyc = cyc;
      pulse_start();
      wait_done("full_done", 5000);
      repeat (5) step();
      check("full_beats", frame_beats, NBEATS);
      check("full_first", int'(frame_log[0]), 1610);
      check("full_b47", int'(frame_log[47]), 1657);
      check("full_b48", int'(frame_log[48]), 1770);
      check("full_last", int'(frame_log[NBEATS-1]), 9177);
      check("full_span", last_cyc - first_cyc, NBEATS - 1);
      check_max("full_latency", first_cyc - start_cyc, 3);
      check("full_done_cyc", done_cyc, last_cyc + 1);
      check("full_done_cnt", done_total - d0, 1);
      check("full_idle", int'(ap_idle), 1);

      // Backpressure
      tready = 1'b0;
      frame_beats = 0;
      r0 = reads_total;
      d0 = done_total;
      push_frame();
      pulse_start();
      repeat (200) step();
      check("bp_tvalid", int'(tvalid), 1);
      check("bp_tdata", int'(tdata), 1610);
      check_max("bp_reads", reads_total - r0, 2);
      tready = 1'b1;
      wait_done("bp_done", 5000);
      repeat (3) step();
      check("bp_beats", frame_beats, NBEATS);
      check("bp_b1", int'(frame_log[1]), 1611);
      check("bp_b2", int'(frame_log[2]), 1612);
      check("bp_done_cnt", done_total - d0, 1);

      // Ten frames with random readiness and start timing; odd frames start
      // in the IDLE cycle right after the previous DONE.
      rand_rdy = 1;
      d0 = done_total;
      b0 = beats_total;
      for (int f = 0; f < 10; f++) begin
         if (f % 2 == 1) begin
            wait_done("rand_b2b", 20000);
         end else begin
            for (int i = 0; i < 20000 && !ap_idle; i++) step();
            repeat ($urandom_range(0, 3)) step();
         end
         push_frame();
         pulse_start();
      end
      for (int i = 0; i < 20000 && (done_total - d0) < 10; i++) step();
      rand_rdy = 0;
      tready = 1'b1;
      repeat (5) step();
      check("rand_done_cnt", done_total - d0, 10);
      check("rand_beats", beats_total - b0, 10 * NBEATS);
      check("rand_sb_empty", sb_q.size(), 0);

      // Reset mid-stream after beat 500
      frame_beats = 0;
      push_frame();
      pulse_start();
      wait_beats("rst_mid_wait", 500, 2000);
      #2;
      ap_rst_n = 1'b0;
      #1;
      check("rst_mid_tvalid", int'(tvalid), 0);
      check("rst_mid_rd_en", int'(img_rd_en), 0);
      check("rst_mid_idle", int'(ap_idle), 1);
      sb_q.delete();
      d0 = done_total;
      repeat (5) step();
      ap_rst_n = 1'b1;
      repeat (10) step();
      check("rst_mid_no_done", done_total - d0, 0);
      frame_beats = 0;
      push_frame();
      pulse_start();
      wait_done("rst_restart_done", 5000);
      repeat (2) step();
      check("rst_restart_first", int'(frame_log[0]), 1610);
      check("rst_restart_beats", frame_beats, NBEATS);

      // ap_start during STREAM and DRAIN is ignored
      frame_beats = 0;
      d0 = done_total;
      push_frame();
      pulse_start();
      wait_beats("ign_stream", 100, 2000);
      pulse_start();
      wait_beats("ign_drain", NBEATS - 2, 5000);
      tready = 1'b0;
      pulse_start();
      repeat (3) step();
      check("ign_drain_no_done", done_total - d0, 0);
      tready = 1'b1;
      wait_done("ign_done", 100);
      repeat (10) step();
      check("ign_done_cnt", done_total - d0, 1);
      check("ign_beats", frame_beats, NBEATS);
      check("ign_idle", int'(ap_idle), 1);
      check("ign_sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/img_crop_streamer.md
IMG_CROP_STREAMER -- requirements
Module: img_crop_streamer

Interface
REQ-001 The block SHALL take parameter FP_TOTAL, default 16: pixel width in bits.
REQ-002 The block SHALL take parameters IN_ROWS and IN_COLS, defaults 100 and 160: source image size.
REQ-003 The block SHALL take parameters OUT_ROWS and OUT_COLS, defaults 48 and 48: crop window size.
REQ-004 The block SHALL take parameters Y_1 and X_1, defaults 10 and 10: top-left corner of the crop window.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports in this order:
- ap_clk  in  1  clock, all logic on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have these control ports:
- ap_start  in  1  start request.
- ap_done  out  1  one-cycle pulse when a frame completes.
- ap_idle  out  1  high when no frame is in progress.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
REQ-007 The block SHALL have these image-memory read ports:
- img_addr  out  AW  read address, AW = clog2(IN_ROWS*IN_COLS).
- img_rd_en  out  1  read strobe.
- img_rdata  in  FP_TOTAL  read data, valid exactly 1 cycle after img_rd_en.
REQ-008 The block SHALL have these AXI-Stream master ports:
- conv2d_1_input_V_data_0_V_TDATA  out  FP_TOTAL  pixel data.
- conv2d_1_input_V_data_0_V_TVALID  out  1  pixel data valid.
- conv2d_1_input_V_data_0_V_TREADY  in  1  downstream ready.

Function
REQ-009 Configurations with Y_1+OUT_ROWS>IN_ROWS or X_1+OUT_COLS>IN_COLS SHALL be unsupported and SHALL fail an elaboration-time check.
REQ-010 The FSM SHALL have four states: IDLE, STREAM (issuing reads), DRAIN (all reads issued, buffer non-empty) and DONE (one cycle).
REQ-011 In IDLE, ap_start=1 SHALL move the FSM to STREAM; ap_start SHALL be ignored in every other state.
REQ-012 The block SHALL read pixels in raster order: row counter r from 0 to OUT_ROWS-1, column counter c from 0 to OUT_COLS-1, with c wrapping to 0 and r incrementing at c=OUT_COLS-1.
REQ-013 img_addr SHALL equal (Y_1+r)*IN_COLS+(X_1+c), built from a row-base register incremented by IN_COLS on each row wrap, with no multiplier.
REQ-014 Read data SHALL land in a 2-entry output FIFO.
REQ-015 img_rd_en SHALL assert only when (FIFO occupancy + reads in flight) < 2, so no pixel is ever dropped.
REQ-016 TVALID SHALL be registered and SHALL be high whenever the FIFO is non-empty; TDATA SHALL be the FIFO head.
REQ-017 A beat SHALL transfer on a cycle with TVALID=1 and TREADY=1.
REQ-018 Once asserted, TVALID SHALL stay high and TDATA SHALL stay stable until the beat transfers.
REQ-019 TVALID SHALL NOT depend combinationally on TREADY.
REQ-020 A simultaneous FIFO push and pop SHALL leave occupancy unchanged; a push into a full FIFO SHALL be impossible by construction (REQ-015).
REQ-021 When TREADY is held high, the first beat SHALL appear at most 3 cycles after ap_start is sampled, and the block SHALL then sustain 1 beat per cycle.
REQ-022 After the final read (r=OUT_ROWS-1, c=OUT_COLS-1), the FSM SHALL go to DRAIN; after the last beat transfers, it SHALL go to DONE.
REQ-023 In DONE, ap_done and ap_ready SHALL both be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-024 Each frame SHALL transfer exactly OUT_ROWS*OUT_COLS beats, with no duplicates and no omissions.
REQ-025 ap_idle SHALL be 1 in IDLE only.
REQ-026 An ap_start sampled in the IDLE cycle directly after DONE SHALL begin a new frame, allowing back-to-back frames.

Reset
REQ-027 Asserting ap_rst_n=0 SHALL immediately (asynchronously) set: FSM=IDLE, r=c=0, row-base=Y_1*IN_COLS+X_1, FIFO empty, in-flight count=0.
REQ-028 During reset: TVALID=0, TDATA=0, img_rd_en=0, img_addr=0, ap_done=0, ap_ready=0, ap_idle=1.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no completion pulse, and the next ap_start SHALL restart at r=c=0.

Verification (memory model: mem[a]=a, default parameters)
REQ-030 Reset check: hold ap_rst_n=0 -> TVALID=0, img_rd_en=0, ap_idle=1, ap_done=0, with outputs clearing before the next clock edge.
REQ-031 Full throughput: TREADY=1, pulse ap_start -> 2304 beats on consecutive cycles, first 1610, beat 47 = 1657, beat 48 = 1770, last 9177; ap_done pulses once, on the cycle after the last beat.
REQ-032 Backpressure: TREADY=0 for 200 cycles after start -> TVALID=1 with TDATA held at 1610, at most 2 reads issued; on TREADY=1 the sequence resumes at 1610, 1611, ... with no gap or duplicate.
REQ-033 Random TREADY and random ap_start for 10 consecutive frames -> every frame is a bit-exact 2304-beat sequence equal to the REQ-031 reference, with 10 ap_done pulses.
REQ-034 Reset mid-stream after beat 500 -> TVALID drops asynchronously and no ap_done occurs; the next ap_start produces a first beat of 1610.
REQ-035 ap_start pulsed during STREAM and during DRAIN -> no effect: beat count stays 2304 and exactly one ap_done pulse occurs.
